// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control unit: op encodings, decoder modes, FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    localparam logic [1:0] MODE_MEM = 2'b00;
    localparam logic [1:0] MODE_BR  = 2'b01;
    localparam logic [1:0] MODE_R   = 2'b10;
    localparam logic [1:0] MODE_I   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_unit_lut.sv
// Combinational decode of (alu_mode, funct3, funct7_5) into an ALU op.
// Illegal-combination flagging is built only with ALU_CTRL_ILLEGAL_EN.
module alu_op_lut
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_mode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] op,
    output logic       is_shift
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic       illegal
`endif
);

    logic is_r;

    assign is_r = (alu_mode == MODE_R);

    always_comb begin
        op       = ALU_ADD;
        is_shift = 1'b0;
        case (alu_mode)
            MODE_MEM: op = ALU_ADD;
            MODE_BR:  op = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  op = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
        endcase

`ifdef ALU_CTRL_ILLEGAL_EN
        illegal = (is_r && funct7_5 && (funct3 != 3'b000) && (funct3 != 3'b101)) ||
                  ((alu_mode == MODE_I) && funct7_5 && (funct3 == 3'b001));
        if (illegal) begin
            op = ALU_ADD;
        end
`endif

        is_shift = (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    end

endmodule

// File: rtl/alu_ctrl_unit.sv
// Registered, handshaked ALU control unit with multi-cycle shift occupancy.
// Define ALU_CTRL_ILLEGAL_EN to add the illegal output and illegal-funct trapping.
module alu_ctrl_unit
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned OP_W      = 4,
    parameter int unsigned SHIFT_LAT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_mode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] alu_op,
    output logic            alu_multi,
    output logic            busy
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic            illegal
`endif
);

    localparam int unsigned CNT_W    = (SHIFT_LAT > 1) ? $clog2(SHIFT_LAT) : 1;
    localparam bit          MULTI_EN = (SHIFT_LAT > 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q, lut_op;
    logic             multi_q, lut_shift;
    logic             accept, handoff;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic             lut_illegal, illegal_q;
`endif

    alu_op_lut u_lut (
        .alu_mode (alu_mode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .op       (lut_op),
        .is_shift (lut_shift)
`ifdef ALU_CTRL_ILLEGAL_EN
        ,
        .illegal  (lut_illegal)
`endif
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (multi_q)       state_nxt = ST_SHIFT;
                    else if (in_valid) state_nxt = ST_HOLD;
                    else               state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cnt == CNT_W'(1)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // in_ready is gated by rst_n so nothing is accepted during reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: in_ready = rst_n;
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = rst_n && out_ready && !multi_q;
            end
            ST_SHIFT: busy = 1'b1;
            default: ;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign handoff = (state == ST_HOLD) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            multi_q   <= 1'b0;
            cnt       <= '0;
`ifdef ALU_CTRL_ILLEGAL_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                op_q      <= lut_op;
                multi_q   <= lut_shift && MULTI_EN;
`ifdef ALU_CTRL_ILLEGAL_EN
                illegal_q <= lut_illegal;
`endif
            end
            if (handoff && multi_q) begin
                cnt <= CNT_W'(SHIFT_LAT - 1);
            end else if (state == ST_SHIFT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign alu_op    = OP_W'(op_q);
    assign alu_multi = multi_q;
`ifdef ALU_CTRL_ILLEGAL_EN
    assign illegal   = illegal_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed self-checking bench for alu_ctrl_unit (OP_W=4, SHIFT_LAT=4).
module tb_alu_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] alu_mode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] alu_op;
    logic       alu_multi;
    logic       busy;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       illegal;
`endif

    int checks   = 0;
    int failures = 0;

    // Index: {I-type, funct7_5, funct3}
`ifdef ALU_CTRL_ILLEGAL_EN
    logic [3:0] exp_tab [32] = '{0,2,3,4,5,6,8,9,  1,0,0,0,0,7,0,0,
                                 0,2,3,4,5,6,8,9,  0,0,3,4,5,7,8,9};
    logic       exp_ill [32] = '{0,0,0,0,0,0,0,0,  0,1,1,1,1,0,1,1,
                                 0,0,0,0,0,0,0,0,  0,1,0,0,0,0,0,0};
`else
    logic [3:0] exp_tab [32] = '{0,2,3,4,5,6,8,9,  1,2,3,4,5,7,8,9,
                                 0,2,3,4,5,6,8,9,  0,2,3,4,5,7,8,9};
`endif

    alu_ctrl_unit #(.OP_W(4), .SHIFT_LAT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_mode  (alu_mode),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .alu_multi (alu_multi),
        .busy      (busy)
`ifdef ALU_CTRL_ILLEGAL_EN
        ,
        .illegal   (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic issue(input logic [1:0] m, input logic [2:0] f3, input logic f7);
        wait_ready();
        alu_mode = m;
        funct3   = f3;
        funct7_5 = f7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((out_valid !== 1'b0 || busy !== 1'b0) && n < 20) begin
            tick();
            n++;
        end
        check("drain_idle", 32'(out_valid | busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [3:0] e;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        alu_mode  = 2'b00;
        funct3    = 3'b000;
        funct7_5  = 1'b0;
        out_ready = 1'b0;

        // Reset held two cycles with a pending request
        tick();
        tick();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_op",    32'(alu_op),    32'd0);
        check("rst_alu_multi", 32'(alu_multi), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
`ifdef ALU_CTRL_ILLEGAL_EN
        check("rst_illegal",   32'(illegal),   32'd0);
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Mem / branch modes ignore funct fields
        out_ready = 1'b1;
        issue(2'b00, 3'b101, 1'b1);
        check("mem_op", 32'(alu_op), 32'd0);
        check("mem_valid", 32'(out_valid), 32'd1);
        issue(2'b01, 3'b111, 1'b0);
        check("br_op", 32'(alu_op), 32'd1);

        // Full R/I table sweep
        for (int m = 0; m < 2; m++) begin
            for (int f7 = 0; f7 < 2; f7++) begin
                for (int f3 = 0; f3 < 8; f3++) begin
                    idx = m * 16 + f7 * 8 + f3;
                    e   = exp_tab[idx];
                    issue(2'b10 | 2'(m), 3'(f3), 1'(f7));
                    check($sformatf("tab_op_%0d", idx), 32'(alu_op), 32'(e));
                    check($sformatf("tab_valid_%0d", idx), 32'(out_valid), 32'd1);
                    check($sformatf("tab_multi_%0d", idx), 32'(alu_multi),
                          (e == 4'd2 || e == 4'd6 || e == 4'd7) ? 32'd1 : 32'd0);
`ifdef ALU_CTRL_ILLEGAL_EN
                    check($sformatf("tab_ill_%0d", idx), 32'(illegal), 32'(exp_ill[idx]));
`endif
                end
            end
        end
        drain();

        // Backpressure: XOR held, AND pending
        out_ready = 1'b0;
        issue(2'b10, 3'b100, 1'b0);
        check("bp_op0", 32'(alu_op), 32'd5);
        alu_mode = 2'b10;
        funct3   = 3'b111;
        funct7_5 = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold_op_%0d", k), 32'(alu_op), 32'd5);
            check($sformatf("bp_hold_rdy_%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("bp_hold_vld_%0d", k), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_same_edge_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_new_op", 32'(alu_op), 32'd9);
        check("bp_new_vld", 32'(out_valid), 32'd1);
        tick();
        check("bp_idle", 32'(out_valid), 32'd0);

        // Shift occupancy: SRL hand-off then pending ADD
        out_ready = 1'b0;
        issue(2'b10, 3'b101, 1'b0);
        check("sh_op", 32'(alu_op), 32'd6);
        check("sh_multi", 32'(alu_multi), 32'd1);
        check("sh_hold_rdy", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        alu_mode = 2'b00;
        funct3   = 3'b000;
        funct7_5 = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sh_busy_%0d", k), 32'(busy), 32'd1);
            check($sformatf("sh_rdy_%0d", k), 32'(in_ready), 32'd0);
            check($sformatf("sh_vld_%0d", k), 32'(out_valid), 32'd0);
            tick();
        end
        check("sh_done_busy", 32'(busy), 32'd0);
        check("sh_done_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("sh_next_vld", 32'(out_valid), 32'd1);
        check("sh_next_op", 32'(alu_op), 32'd0);
        check("sh_next_multi", 32'(alu_multi), 32'd0);
        drain();

        // Reset during SHIFT
        out_ready = 1'b1;
        issue(2'b10, 3'b001, 1'b0);
        check("rs_op", 32'(alu_op), 32'd2);
        tick();
        check("rs_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rs_busy", 32'(busy), 32'd0);
        check("rs_vld", 32'(out_valid), 32'd0);
        check("rs_op_clr", 32'(alu_op), 32'd0);
        check("rs_rdy_low", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rs_rdy_rel", 32'(in_ready), 32'd1);

        // Illegal R-type funct3=100 with funct7_5=1
        issue(2'b10, 3'b100, 1'b1);
`ifdef ALU_CTRL_ILLEGAL_EN
        check("ill_op", 32'(alu_op), 32'd0);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_multi", 32'(alu_multi), 32'd0);
        issue(2'b10, 3'b110, 1'b0);
        check("ill_clr_flag", 32'(illegal), 32'd0);
        check("ill_clr_op", 32'(alu_op), 32'd8);
`else
        check("ill_op", 32'(alu_op), 32'd5);
        issue(2'b11, 3'b001, 1'b1);
        check("ill_slli_op", 32'(alu_op), 32'd2);
        check("ill_slli_multi", 32'(alu_multi), 32'd1);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
